// File: rtl/bus_uart_tx_pkg.sv
// Shared definitions for bus_uart_tx: register offsets, STATUS bit positions,
// transmitter FSM state encoding and frame constants.
package bus_uart_tx_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [1:0] RegTxdata  = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegDivisor = 2'd2;

  // STATUS bit positions; count occupies bits [7:4]
  localparam int unsigned StatEmptyBit   = 0;
  localparam int unsigned StatFullBit    = 1;
  localparam int unsigned StatBusyBit    = 2;
  localparam int unsigned StatOverrunBit = 3;
  localparam int unsigned StatCountLsb   = 4;

  // Frame constants
  localparam int unsigned DataBits = 8;
  localparam logic [2:0]  LastBit  = 3'(DataBits - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count.
// Ports:
//   clock, reset      : clock and asynchronous active-high reset
//   push, push_data   : write request and data (dropped when full)
//   pop, pop_data     : read request (ignored when empty) and head-of-queue data
//   empty, full, count: occupancy flags and entry count (0..2**DEPTH_LOG2)
module byte_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned          Depth     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  FullCount = (DEPTH_LOG2 + 1)'(Depth);

  logic [WIDTH-1:0]      mem [Depth];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FullCount);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 serial transmitter on the cpu device bus.
// Registers (word offsets from BASE_ADDR): 0 TXDATA (wo), 1 STATUS (ro), 2 DIVISOR (rw).
// Ports:
//   clock, reset                : clock, asynchronous active-high reset
//   address, data               : cpu word address, bidirectional data bus
//   rd_n, wr_n, csh_n, csl_n    : active-low read/write strobes and byte selects
//   select_dev                  : 1 = device-space access
//   tx                          : serial output, idle high
//   irq                         : FIFO empty and shifter idle (registered)
// Optional: define BUS_UART_TX_PARITY_EN to add an even-parity bit, enabled by DIVISOR[15].
module bus_uart_tx
  import bus_uart_tx_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR       = 15'h0010,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3,
  parameter logic [15:0] DIV_RESET       = 16'd16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] address,
  inout  wire  [15:0] data,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        csh_n,
  input  logic        csl_n,
  input  logic        select_dev,
  output logic        tx,
  output logic        irq
);

  logic                     sel;
  logic [1:0]               reg_idx;
  logic                     wr_prev, rd_prev;
  logic                     wr_fire, rd_fire;
  logic                     push, pop;
  logic [7:0]               fifo_rdata;
  logic                     fifo_empty, fifo_full;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic                     overrun;
  logic [15:0]              divisor;
  logic [15:0]              div_raw, div_eff, baud_load;
  logic                     parity_en;
  logic [15:0]              status_word, rd_word;

  tx_state_e   state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        parity_bit;
  logic        bit_end;

  assign sel     = select_dev && (address >= BASE_ADDR) && (address <= BASE_ADDR + 15'd2);
  assign reg_idx = 2'(address - BASE_ADDR);

  // Only the first sampled edge of a strobe counts, so long strobes act once.
  assign wr_fire = sel && !wr_n && wr_prev;
  assign rd_fire = sel && !rd_n && rd_prev;
  assign push    = wr_fire && (reg_idx == RegTxdata) && !csl_n;

`ifdef BUS_UART_TX_PARITY_EN
  assign div_raw   = {1'b0, divisor[14:0]};
  assign parity_en = divisor[15];
`else
  assign div_raw   = divisor;
  assign parity_en = 1'b0;
`endif
  assign div_eff   = (div_raw == 16'd0) ? 16'd1 : div_raw;
  assign baud_load = div_eff - 16'd1;

  assign bit_end = (baud_cnt == 16'd0);
  assign pop     = !fifo_empty && ((state == StIdle) || ((state == StStop) && bit_end));

  byte_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_comb begin
    status_word = '0;
    status_word[StatEmptyBit]          = fifo_empty;
    status_word[StatFullBit]           = fifo_full;
    status_word[StatBusyBit]           = (state != StIdle);
    status_word[StatOverrunBit]        = overrun;
    status_word[StatCountLsb +: 4]     = 4'(fifo_count);
  end

  always_comb begin
    rd_word = '0;
    case (reg_idx)
      RegStatus:  rd_word = status_word;
      RegDivisor: rd_word = divisor;
      default:    rd_word = '0;
    endcase
    if (csh_n) rd_word[15:8] = 8'h00;
    if (csl_n) rd_word[7:0]  = 8'h00;
  end

  assign data = (sel && !rd_n) ? rd_word : 16'hzzzz;

  // Bus registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_prev <= 1'b1;
      rd_prev <= 1'b1;
      overrun <= 1'b0;
      divisor <= DIV_RESET;
    end else begin
      wr_prev <= wr_n;
      rd_prev <= rd_n;
      // A new overrun wins over a simultaneous clearing read.
      if (push && fifo_full) begin
        overrun <= 1'b1;
      end else if (rd_fire && (reg_idx == RegStatus) && !csl_n) begin
        overrun <= 1'b0;
      end
      if (wr_fire && (reg_idx == RegDivisor)) begin
        if (!csh_n) divisor[15:8] <= data[15:8];
        if (!csl_n) divisor[7:0]  <= data[7:0];
      end
    end
  end

  // Transmit FSM; the divisor is sampled at every bit start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      irq        <= 1'b1;
    end else begin
      irq <= fifo_empty && (state == StIdle);
      case (state)
        StIdle: begin
          tx <= 1'b1;
          if (pop) begin
            shift      <= fifo_rdata;
            parity_bit <= ^fifo_rdata;
            baud_cnt   <= baud_load;
            tx         <= 1'b0;
            state      <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            tx       <= shift[0];
            bit_cnt  <= LastBit;
            baud_cnt <= baud_load;
            state    <= StData;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        StData: begin
          if (bit_end) begin
            baud_cnt <= baud_load;
            if (bit_cnt == 3'd0) begin
              if (parity_en) begin
                tx    <= parity_bit;
                state <= StParity;
              end else begin
                tx    <= 1'b1;
                state <= StStop;
              end
            end else begin
              tx      <= shift[1];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt - 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        StParity: begin
          if (bit_end) begin
            tx       <= 1'b1;
            baud_cnt <= baud_load;
            state    <= StStop;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        StStop: begin
          if (bit_end) begin
            if (pop) begin
              // Back-to-back frame: next start bit follows the stop bit directly.
              shift      <= fifo_rdata;
              parity_bit <= ^fifo_rdata;
              baud_cnt   <= baud_load;
              tx         <= 1'b0;
              state      <= StStart;
            end else begin
              tx    <= 1'b1;
              state <= StIdle;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
